// File: rtl/ssram_stream_dma.sv
// +----------------------------------------------------------------------------+
// | ssram_stream_dma: dual-port SSRAM, port A for CPU access, port B for a     |
// | stream fill/drain DMA engine. Optional macro SSRAM_STREAM_DMA_CHECKSUM_EN. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module ssram_stream_dma #(
  parameter int BIT_WIDTH     = 32,
  parameter int NR_OF_ENTRIES = 512,
  localparam int ADDR_WIDTH   = $clog2(NR_OF_ENTRIES),
  localparam int LEN_WIDTH    = ADDR_WIDTH + 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] cpuAddress,
  input  logic                  cpuWriteEnable,
  input  logic [BIT_WIDTH-1:0]  cpuDataIn,
  output logic [BIT_WIDTH-1:0]  cpuDataOut,
  input  logic                  dmaStart,
  input  logic                  dmaDirection,
  input  logic [ADDR_WIDTH-1:0] dmaStartAddress,
  input  logic [LEN_WIDTH-1:0]  dmaLength,
  input  logic                  dmaAbort,
  output logic                  dmaBusy,
  output logic                  dmaDone,
  output logic [LEN_WIDTH-1:0]  dmaWordsDone,
  input  logic [BIT_WIDTH-1:0]  inData,
  input  logic                  inValid,
  output logic                  inReady,
  output logic [BIT_WIDTH-1:0]  outData,
  output logic                  outValid,
  input  logic                  outReady
`ifdef SSRAM_STREAM_DMA_CHECKSUM_EN
  ,
  output logic [BIT_WIDTH-1:0]  dmaChecksum
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  logic [BIT_WIDTH-1:0]  mem [NR_OF_ENTRIES];

  state_t                r_state;
  state_t                w_nextState;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [LEN_WIDTH-1:0]  r_length;
  logic [LEN_WIDTH-1:0]  r_toIssue;
  logic [LEN_WIDTH-1:0]  r_wordsDone;
  logic [BIT_WIDTH-1:0]  r_buf [2];
  logic                  r_head;
  logic [1:0]            r_count;

  logic                  w_start;
  logic                  w_inHs;
  logic                  w_outHs;
  logic                  w_issue;
  logic                  w_lastHs;
  logic                  w_tail;
  logic [LEN_WIDTH-1:0]  w_satLen;

  assign inReady      = (r_state == FILL);
  assign outValid     = (r_count != 2'd0);
  assign outData      = r_buf[r_head];
  assign dmaBusy      = (r_state == FILL) || (r_state == DRAIN);
  assign dmaDone      = (r_state == DONE);
  assign dmaWordsDone = r_wordsDone;

  assign w_start  = (r_state == IDLE) && dmaStart;
  assign w_inHs   = inValid && inReady;
  assign w_outHs  = outValid && outReady;
  assign w_satLen = (dmaLength > LEN_WIDTH'(NR_OF_ENTRIES)) ? LEN_WIDTH'(NR_OF_ENTRIES) : dmaLength;
  // Read data lands in the buffer at the issuing edge, so nothing is ever left in flight.
  assign w_issue  = (r_state == DRAIN) && !dmaAbort && (r_toIssue != '0) && (r_count != 2'd2);
  assign w_lastHs = (w_inHs || w_outHs) && ((r_wordsDone + LEN_WIDTH'(1)) == r_length);
  assign w_tail   = r_head ^ r_count[0];

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (dmaStart) begin
          if (w_satLen == '0)    w_nextState = DONE;
          else if (dmaDirection) w_nextState = DRAIN;
          else                   w_nextState = FILL;
        end
      end
      FILL, DRAIN: begin
        if (dmaAbort)      w_nextState = IDLE;
        else if (w_lastHs) w_nextState = DONE;
      end
      DONE:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_nextState;
  end

  // Port A is written last so it wins an address collision with the engine.
  always_ff @(posedge clock) begin
    if (w_inHs)         mem[r_addr]     <= inData;
    if (cpuWriteEnable) mem[cpuAddress] <= cpuDataIn;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) cpuDataOut <= '0;
    else       cpuDataOut <= mem[cpuAddress];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_addr      <= '0;
      r_length    <= '0;
      r_toIssue   <= '0;
      r_wordsDone <= '0;
    end else if (w_start) begin
      r_addr      <= dmaStartAddress;
      r_length    <= w_satLen;
      r_toIssue   <= w_satLen;
      r_wordsDone <= '0;
    end else begin
      if (w_inHs || w_outHs) r_wordsDone <= r_wordsDone + LEN_WIDTH'(1);
      if (w_inHs || w_issue) r_addr      <= r_addr + ADDR_WIDTH'(1);
      if (w_issue)           r_toIssue   <= r_toIssue - LEN_WIDTH'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_buf[0] <= '0;
      r_buf[1] <= '0;
      r_head   <= 1'b0;
      r_count  <= 2'd0;
    end else if (dmaAbort && dmaBusy) begin
      r_head  <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (w_issue) r_buf[w_tail] <= mem[r_addr];
      if (w_outHs) r_head        <= ~r_head;
      r_count <= r_count + 2'(w_issue) - 2'(w_outHs);
    end
  end

`ifdef SSRAM_STREAM_DMA_CHECKSUM_EN
  logic [BIT_WIDTH-1:0] r_checksum;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)        r_checksum <= '0;
    else if (w_start) r_checksum <= '0;
    else if (w_inHs)  r_checksum <= r_checksum + inData;
    else if (w_outHs) r_checksum <= r_checksum + outData;
  end

  assign dmaChecksum = r_checksum;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ssram_stream_dma.sv
// +----------------------------------------------------------------------------+
// | tb_ssram_stream_dma: directed self-checking bench for ssram_stream_dma.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_ssram_stream_dma;

  localparam int BW = 32;
  localparam int AW = 9;
  localparam int LW = 10;

  logic          clock = 1'b0;
  logic          reset;
  logic [AW-1:0] cpuAddress;
  logic          cpuWriteEnable;
  logic [BW-1:0] cpuDataIn;
  logic [BW-1:0] cpuDataOut;
  logic          dmaStart;
  logic          dmaDirection;
  logic [AW-1:0] dmaStartAddress;
  logic [LW-1:0] dmaLength;
  logic          dmaAbort;
  logic          dmaBusy;
  logic          dmaDone;
  logic [LW-1:0] dmaWordsDone;
  logic [BW-1:0] inData;
  logic          inValid;
  logic          inReady;
  logic [BW-1:0] outData;
  logic          outValid;
  logic          outReady;
`ifdef SSRAM_STREAM_DMA_CHECKSUM_EN
  logic [BW-1:0] dmaChecksum;
`endif

  int checks = 0;
  int errors = 0;

  ssram_stream_dma #(.BIT_WIDTH(BW), .NR_OF_ENTRIES(512)) dut (
    .clock(clock), .reset(reset),
    .cpuAddress(cpuAddress), .cpuWriteEnable(cpuWriteEnable),
    .cpuDataIn(cpuDataIn), .cpuDataOut(cpuDataOut),
    .dmaStart(dmaStart), .dmaDirection(dmaDirection),
    .dmaStartAddress(dmaStartAddress), .dmaLength(dmaLength),
    .dmaAbort(dmaAbort), .dmaBusy(dmaBusy), .dmaDone(dmaDone),
    .dmaWordsDone(dmaWordsDone),
    .inData(inData), .inValid(inValid), .inReady(inReady),
    .outData(outData), .outValid(outValid), .outReady(outReady)
`ifdef SSRAM_STREAM_DMA_CHECKSUM_EN
    , .dmaChecksum(dmaChecksum)
`endif
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [BW-1:0] din;
    logic [BW-1:0] exp;
  } vec_t;

  vec_t vecs [7];

  function automatic logic [BW-1:0] word(input int i);
    return 32'h00010203 + 32'h04040404 * i;
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic startDma(input logic dir, input int addr, input int len);
    dmaStart        = 1'b1;
    dmaDirection    = dir;
    dmaStartAddress = AW'(addr);
    dmaLength       = LW'(len);
    step();
    dmaStart = 1'b0;
  endtask

  task automatic readA(input int addr, input logic [BW-1:0] exp, input string name);
    cpuAddress = AW'(addr);
    step();
    chk(name, cpuDataOut, exp);
  endtask

  initial begin
    int k;
    int hs;
    logic fin;

    reset = 1'b1;
    cpuAddress = '0; cpuWriteEnable = 1'b0; cpuDataIn = '0;
    dmaStart = 1'b0; dmaDirection = 1'b0; dmaStartAddress = '0; dmaLength = '0;
    dmaAbort = 1'b0; inData = '0; inValid = 1'b0; outReady = 1'b0;
    repeat (2) step();
    chk("reset_ctrl", {dmaBusy, dmaDone, dmaWordsDone, inReady, outValid}, '0);
    chk("reset_data", {outData, cpuDataOut}, '0);
    reset = 1'b0;
    step();

    // Fill 64 words from address 0 with inValid held high.
    startDma(1'b0, 0, 64);
    chk("fill_busy", dmaBusy, 1);
    inValid = 1'b1;
    for (int i = 0; i < 64; i++) begin
      inData = word(i);
      chk("fill_inReady", inReady, 1);
      step();
    end
    inValid = 1'b0;
    chk("fill_done", dmaDone, 1);
    chk("fill_busy_in_done", dmaBusy, 0);
    chk("fill_inReady_drop", inReady, 0);
    chk("fill_words", dmaWordsDone, 64);
    step();
    chk("fill_done_once", dmaDone, 0);
    for (int i = 0; i < 64; i++) readA(i, word(i), "fill_readback");

    // Port-A read-during-write returns old data.
    vecs[0] = '{1'b1, 9'd20, 32'hCAFE0001, word(20)};
    vecs[1] = '{1'b0, 9'd20, 32'h0,        32'hCAFE0001};
    vecs[2] = '{1'b1, 9'd21, 32'h12345678, word(21)};
    vecs[3] = '{1'b0, 9'd21, 32'h0,        32'h12345678};
    vecs[4] = '{1'b0, 9'd22, 32'h0,        word(22)};
    vecs[5] = '{1'b1, 9'd20, 32'h0BADF00D, 32'hCAFE0001};
    vecs[6] = '{1'b0, 9'd20, 32'h0,        32'h0BADF00D};
    for (int i = 0; i < 7; i++) begin
      cpuWriteEnable = vecs[i].we;
      cpuAddress     = vecs[i].addr;
      cpuDataIn      = vecs[i].din;
      step();
      chk("portA_vec", cpuDataOut, vecs[i].exp);
    end
    cpuWriteEnable = 1'b0;

    for (int i = 0; i < 8; i++) begin
      cpuWriteEnable = 1'b1;
      cpuAddress     = AW'(10 + i);
      cpuDataIn      = 32'hA0000000 + i;
      step();
    end
    cpuWriteEnable = 1'b0;

    // Drain with outReady toggling; data must hold while stalled.
    startDma(1'b1, 10, 8);
    chk("drain_lat_s1", outValid, 0);
    step();
    chk("drain_lat_s2", outValid, 1);
    k = 0;
    for (int cyc = 0; cyc < 40 && k < 8; cyc++) begin
      outReady = (cyc % 2 == 0);
      chk("drain_valid", outValid, 1);
      chk("drain_data", outData, 32'hA0000000 + k);
      if (outReady) k++;
      step();
    end
    outReady = 1'b0;
    chk("drain_count", k, 8);
    chk("drain_done", dmaDone, 1);
    chk("drain_words", dmaWordsDone, 8);
    step();

    // Drain with outReady high: one word per cycle.
    outReady = 1'b1;
    startDma(1'b1, 10, 8);
    step();
    for (int i = 0; i < 8; i++) begin
      chk("stream_valid", outValid, 1);
      chk("stream_data", outData, 32'hA0000000 + i);
      step();
    end
    outReady = 1'b0;
    chk("stream_done", dmaDone, 1);
    step();

    // Address wrap from the last entry.
    startDma(1'b0, 510, 4);
    inValid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      inData = 32'h11 + i;
      chk("wrap_inReady", inReady, 1);
      step();
    end
    inValid = 1'b0;
    chk("wrap_done", dmaDone, 1);
    step();
    readA(510, 32'h11, "wrap_510");
    readA(511, 32'h12, "wrap_511");
    readA(0,   32'h13, "wrap_0");
    readA(1,   32'h14, "wrap_1");

    // Length above depth saturates.
    outReady = 1'b1;
    startDma(1'b1, 0, 600);
    hs = 0;
    fin = 1'b0;
    for (int cyc = 0; cyc < 700 && !fin; cyc++) begin
      if (dmaDone) fin = 1'b1;
      else begin
        if (outValid) hs++;
        step();
      end
    end
    outReady = 1'b0;
    chk("sat_done", fin, 1);
    chk("sat_handshakes", hs, 512);
    chk("sat_words", dmaWordsDone, 512);
    step();

    // Zero length completes without handshakes.
    startDma(1'b0, 5, 0);
    chk("len0_done", dmaDone, 1);
    chk("len0_idle", {dmaBusy, inReady, outValid, dmaWordsDone}, '0);
    step();
    chk("len0_done_once", dmaDone, 0);

    // dmaStart during FILL is ignored.
    startDma(1'b0, 100, 4);
    inValid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      inData = 32'h55 + i;
      if (i == 1) begin
        dmaStart = 1'b1; dmaDirection = 1'b1; dmaStartAddress = 9'd300; dmaLength = 10'd9;
      end
      chk("busystart_inReady", inReady, 1);
      step();
      dmaStart = 1'b0;
    end
    inValid = 1'b0;
    chk("busystart_done", dmaDone, 1);
    chk("busystart_words", dmaWordsDone, 4);
    step();
    for (int i = 0; i < 4; i++) readA(100 + i, 32'h55 + i, "busystart_readback");

    // Abort after three drained words.
    outReady = 1'b1;
    startDma(1'b1, 10, 8);
    step();
    for (int i = 0; i < 3; i++) begin
      chk("abort_pre_data", outData, 32'hA0000000 + i);
      step();
    end
    outReady = 1'b0;
    dmaAbort = 1'b1;
    step();
    dmaAbort = 1'b0;
    chk("abort_outValid", outValid, 0);
    chk("abort_busy", dmaBusy, 0);
    chk("abort_no_done", dmaDone, 0);
    chk("abort_words", dmaWordsDone, 3);
    step();
    chk("abort_no_done_later", dmaDone, 0);

    // Abort together with start in IDLE: start wins.
    dmaAbort = 1'b1;
    startDma(1'b0, 200, 3);
    dmaAbort = 1'b0;
    chk("abortstart_busy", dmaBusy, 1);
    // Collision: port A overwrites the engine's write to 201.
    inValid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      inData = 32'(i + 1);
      if (i == 1) begin
        cpuWriteEnable = 1'b1; cpuAddress = 9'd201; cpuDataIn = 32'hDEADBEEF;
      end
      step();
      cpuWriteEnable = 1'b0;
    end
    inValid = 1'b0;
    chk("collide_done", dmaDone, 1);
    step();
    readA(200, 32'h1,        "collide_200");
    readA(201, 32'hDEADBEEF, "collide_201");
    readA(202, 32'h3,        "collide_202");

`ifdef SSRAM_STREAM_DMA_CHECKSUM_EN
    startDma(1'b0, 400, 16);
    chk("csum_cleared", dmaChecksum, 0);
    inValid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      inData = 32'(i + 1);
      step();
    end
    inValid = 1'b0;
    chk("csum_done", dmaChecksum, 136);
    step();
    chk("csum_held", dmaChecksum, 136);
`endif

    // Asynchronous reset in the middle of a drain.
    startDma(1'b1, 10, 8);
    step();
    chk("rstmid_pre_valid", outValid, 1);
    #2 reset = 1'b1;
    #1;
    chk("rstmid_ctrl", {dmaBusy, dmaDone, dmaWordsDone, inReady, outValid}, '0);
    chk("rstmid_data", {outData, cpuDataOut}, '0);
`ifdef SSRAM_STREAM_DMA_CHECKSUM_EN
    chk("rstmid_csum", dmaChecksum, 0);
`endif
    reset = 1'b0;
    step();
    chk("rstmid_idle", dmaBusy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
